// File: rtl/serial_subt_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_subt_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subt_ctrl_full_subt_bit.sv
// One-bit full subtractor assembled from two half-subtractor primitives.
module half_subt (
   input  logic i_a,
   input  logic i_b,
   output logic o_diff,
   output logic o_borrow
);
   assign o_diff   = i_a ^ i_b;
   assign o_borrow = ~i_a & i_b;
endmodule

module full_subt_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_diff,
   output logic o_borrow
);
   logic d1, b1, b2;

   half_subt u_hs_ab (
      .i_a      (i_a),
      .i_b      (i_b),
      .o_diff   (d1),
      .o_borrow (b1)
   );

   // Second stage subtracts the incoming borrow; only one stage can borrow at a time.
   half_subt u_hs_bin (
      .i_a      (d1),
      .i_b      (i_bin),
      .o_diff   (o_diff),
      .o_borrow (b2)
   );

   assign o_borrow = b1 | b2;
endmodule

// File: rtl/serial_subt_ctrl.sv
// Bit-serial A - B controller: one full-subtract slice reused LSB first over WIDTH cycles.
module serial_subt_ctrl
   import serial_subt_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t         state, state_next;
   logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
   logic           bin, borrow_out;
   logic [CW-1:0]  count;
   logic           slice_d, slice_bout;
   logic           accept, last_bit;

   full_subt_bit u_slice (
      .i_a      (a_sr[0]),
      .i_b      (b_sr[0]),
      .i_bin    (bin),
      .o_diff   (slice_d),
      .o_borrow (slice_bout)
   );

   assign accept   = (state != RUN) && i_start;
   assign last_bit = (count == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = i_start ? RUN : IDLE;
         RUN:     state_next = last_bit ? DONE : RUN;
         DONE:    state_next = i_start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == RUN);
      o_done = (state == DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         diff_sr    <= '0;
         bin        <= 1'b0;
         borrow_out <= 1'b0;
         count      <= '0;
      end else if (accept) begin
         a_sr  <= i_a;
         b_sr  <= i_b;
         bin   <= 1'b0;
         count <= '0;
      end else if (state == RUN) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         diff_sr <= {slice_d, diff_sr[WIDTH-1:1]};
         bin     <= slice_bout;
         count   <= count + CW'(1);
         if (last_bit) borrow_out <= slice_bout;
      end
   end

   assign o_diff   = diff_sr;
   assign o_borrow = borrow_out;
endmodule

// File: tb/tb_serial_subt_ctrl.sv
// Directed self-checking bench for serial_subt_ctrl at WIDTH=8.
module tb_serial_subt_ctrl;
   localparam int WIDTH = 8;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_start;
   logic [WIDTH-1:0] i_a, i_b;
   logic             o_busy, o_done, o_borrow;
   logic [WIDTH-1:0] o_diff;

   int n_checks = 0;
   int n_fail   = 0;

   serial_subt_ctrl #(.WIDTH(WIDTH)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_diff   (o_diff),
      .o_borrow (o_borrow)
   );

   always #5 i_clk = ~i_clk;

   // Drive a one-cycle start; returns at the first negedge after the sampling edge.
   task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      i_start = 1'b1;
      i_a     = a;
      i_b     = b;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 40) begin
         @(negedge i_clk);
         cyc++;
      end
      ok = (o_done === 1'b1);
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
      repeat (3) @(negedge i_clk);
      n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_checks++; if (o_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
      n_checks++; if (o_diff !== 8'h00)  begin n_fail++; $display("FAIL reset_diff: got %h want 00", o_diff); end
      n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b want 0", o_borrow); end
      i_rst = 1'b0;
      @(negedge i_clk);
      $display("txn reset: busy=%b done=%b diff=%h borrow=%b", o_busy, o_done, o_diff, o_borrow);
   endtask

   task automatic test_basic;
      int busy_cnt = 0;
      int early_done = 0;
      do_start(8'h5A, 8'h3C);
      for (int i = 0; i < WIDTH; i++) begin
         if (o_busy === 1'b1) busy_cnt++;
         if (o_done !== 1'b0) early_done++;
         @(negedge i_clk);
      end
      n_checks++; if (busy_cnt != WIDTH) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cnt, WIDTH); end
      n_checks++; if (early_done != 0)   begin n_fail++; $display("FAIL basic_early_done: got %0d want 0", early_done); end
      n_checks++; if (o_done !== 1'b1)   begin n_fail++; $display("FAIL basic_done_9th: got %b want 1", o_done); end
      n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL basic_busy_in_done: got %b want 0", o_busy); end
      n_checks++; if (o_diff !== 8'h1E)  begin n_fail++; $display("FAIL basic_diff: got %h want 1e", o_diff); end
      n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL basic_borrow: got %b want 0", o_borrow); end
      @(negedge i_clk);
      n_checks++; if (o_done !== 1'b0)   begin n_fail++; $display("FAIL basic_done_width: got %b want 0", o_done); end
      $display("txn basic: 5a-3c diff=%h borrow=%b", o_diff, o_borrow);
   endtask

   task automatic test_underflow;
      int cyc; bit ok;
      do_start(8'h00, 8'h01);
      wait_done(cyc, ok);
      n_checks++; if (!ok || cyc != WIDTH) begin n_fail++; $display("FAIL uf1_latency: got %0d (done=%b) want %0d", cyc, ok, WIDTH); end
      n_checks++; if (o_diff !== 8'hFF)    begin n_fail++; $display("FAIL uf1_diff: got %h want ff", o_diff); end
      n_checks++; if (o_borrow !== 1'b1)   begin n_fail++; $display("FAIL uf1_borrow: got %b want 1", o_borrow); end
      $display("txn underflow: 00-01 diff=%h borrow=%b", o_diff, o_borrow);
      @(negedge i_clk);
      do_start(8'h80, 8'hFF);
      wait_done(cyc, ok);
      n_checks++; if (!ok)                 begin n_fail++; $display("FAIL uf2_timeout: got no done want done"); end
      n_checks++; if (o_diff !== 8'h81)    begin n_fail++; $display("FAIL uf2_diff: got %h want 81", o_diff); end
      n_checks++; if (o_borrow !== 1'b1)   begin n_fail++; $display("FAIL uf2_borrow: got %b want 1", o_borrow); end
      $display("txn underflow: 80-ff diff=%h borrow=%b", o_diff, o_borrow);
      @(negedge i_clk);
   endtask

   task automatic test_reset_mid_op;
      int cyc; bit ok;
      int extra_done = 0;
      // Prior result 0x81/borrow=1 leaves non-zero partial bits in the diff register.
      do_start(8'h40, 8'h20);
      repeat (3) @(negedge i_clk);
      n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", o_busy); end
      #2 i_rst = 1'b1;
      #1;
      n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
      n_checks++; if (o_diff !== 8'h00)  begin n_fail++; $display("FAIL rst_mid_diff: got %h want 00", o_diff); end
      n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_borrow: got %b want 0", o_borrow); end
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge i_clk);
         if (o_done !== 1'b0) extra_done++;
      end
      n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d want 0", extra_done); end
      do_start(8'h40, 8'h20);
      wait_done(cyc, ok);
      n_checks++; if (!ok || o_diff !== 8'h20) begin n_fail++; $display("FAIL rst_mid_rerun_diff: got %h (done=%b) want 20", o_diff, ok); end
      n_checks++; if (o_borrow !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_rerun_borrow: got %b want 0", o_borrow); end
      $display("txn reset_mid_op: 40-20 diff=%h borrow=%b", o_diff, o_borrow);
      @(negedge i_clk);
   endtask

   task automatic test_equal_hold;
      int cyc; bit ok;
      int drift = 0;
      do_start(8'hFF, 8'hFF);
      wait_done(cyc, ok);
      n_checks++; if (!ok || o_diff !== 8'h00) begin n_fail++; $display("FAIL eq_diff: got %h (done=%b) want 00", o_diff, ok); end
      n_checks++; if (o_borrow !== 1'b0)       begin n_fail++; $display("FAIL eq_borrow: got %b want 0", o_borrow); end
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_diff !== 8'h00 || o_borrow !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) drift++;
      end
      n_checks++; if (drift != 0) begin n_fail++; $display("FAIL eq_hold: got %0d disturbed cycles want 0", drift); end
      $display("txn equal: ff-ff diff=%h borrow=%b held 20 cycles", o_diff, o_borrow);
   endtask

   task automatic test_start_while_busy;
      int cyc; bit ok;
      int done_cnt = 0;
      do_start(8'h10, 8'h01);
      repeat (2) @(negedge i_clk);
      do_start(8'hAA, 8'h55);
      wait_done(cyc, ok);
      n_checks++; if (!ok || o_diff !== 8'h0F) begin n_fail++; $display("FAIL busy_start_diff: got %h (done=%b) want 0f", o_diff, ok); end
      n_checks++; if (o_borrow !== 1'b0)       begin n_fail++; $display("FAIL busy_start_borrow: got %b want 0", o_borrow); end
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_done === 1'b1) done_cnt++;
      end
      n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL busy_start_extra_done: got %0d want 0", done_cnt); end
      $display("txn start_while_busy: 10-01 diff=%h borrow=%b", o_diff, o_borrow);
   endtask

   task automatic test_back_to_back;
      int cyc; bit ok;
      do_start(8'h5A, 8'h3C);
      wait_done(cyc, ok);
      n_checks++; if (!ok || o_diff !== 8'h1E) begin n_fail++; $display("FAIL b2b_first_diff: got %h (done=%b) want 1e", o_diff, ok); end
      do_start(8'h03, 8'h05);
      wait_done(cyc, ok);
      n_checks++; if (!ok || cyc != WIDTH) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", cyc + 1, WIDTH + 1); end
      n_checks++; if (o_diff !== 8'hFE)    begin n_fail++; $display("FAIL b2b_diff: got %h want fe", o_diff); end
      n_checks++; if (o_borrow !== 1'b1)   begin n_fail++; $display("FAIL b2b_borrow: got %b want 1", o_borrow); end
      $display("txn back_to_back: 03-05 diff=%h borrow=%b", o_diff, o_borrow);
      @(negedge i_clk);
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_basic();
      test_underflow();
      test_reset_mid_op();
      test_equal_hold();
      test_start_while_busy();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_subt_ctrl.md
Name: serial_subt_ctrl

Overview:
- Bit-serial unsigned subtractor controller that computes A − B.
- Time-shares one single-bit subtract slice over WIDTH clock cycles, LSB first.
- Provides a start/done handshake, so wide subtractions cost one bit-slice plus shift registers instead of a WIDTH-bit ripple array.
- Sits between a requesting datapath and the existing half-subtractor primitive.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 2.

Ports:
- i_clk  input  1  system clock, rising-edge active
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  request pulse; sampled only when the controller is not busy
- i_a  input  WIDTH  minuend, unsigned; captured on an accepted start
- i_b  input  WIDTH  subtrahend, unsigned; captured on an accepted start
- o_busy  output  1  high while a subtraction is in progress
- o_done  output  1  one-cycle pulse: result is valid
- o_diff  output  WIDTH  (i_a − i_b) mod 2^WIDTH
- o_borrow  output  1  final borrow-out; 1 when i_a < i_b

Behaviour:
- Single clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state = IDLE; o_busy = 0; o_done = 0; o_diff = 0; o_borrow = 0; internal shift registers, borrow flop and bit counter all 0.
- Reset mid-operation aborts immediately. No o_done pulse follows, and the outputs return to their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If i_start = 1 at a rising edge: load i_a and i_b into shift registers, clear the borrow flop, set count = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (o_busy = 1), at each edge:
  - Slice inputs: a_bit = LSB of A shift register, b_bit = LSB of B shift register, bin = borrow flop.
  - d = a_bit ^ b_bit ^ bin.
  - bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin).
  - Shift A and B right by one.
  - Shift d into the MSB of the o_diff register (right shift).
  - Borrow flop ← bout; count ← count + 1.
  - When count == WIDTH−1 at the edge, this is the last bit: go to DONE and load o_borrow ← bout.
- RUN lasts exactly WIDTH edges. o_diff is a partial value during RUN and must not be used until o_done.
- DONE (o_busy = 0):
  - o_done = 1 for exactly this one cycle; o_diff and o_borrow hold the final result.
  - Next state is IDLE, or RUN if i_start = 1 (back-to-back start is accepted in DONE with a fresh operand capture).
- Latency: o_done is high in the cycle following the WIDTH-th rising edge after the edge that sampled i_start. Throughput is one result per WIDTH+1 cycles.
- o_diff and o_borrow hold the last result until the next accepted start. From that start they are undefined-for-use until o_done.
- i_start while in RUN is ignored; operand changes during RUN have no effect.
- Counter width is $clog2(WIDTH). It must not wrap before the final bit; it is cleared on every accepted start.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, full_subt_bit: combinational 1-bit full subtractor built from two half_subt instances plus an OR of their borrows.
  - Ports: i_a, i_b, i_bin, o_diff, o_borrow.
  - The controller instantiates it once as the serial slice.

Test Plan (WIDTH=8):
- Basic: i_a=0x5A, i_b=0x3C, start pulse → o_busy high 8 cycles; o_done pulses once in the 9th cycle after the start edge; o_diff=0x1E, o_borrow=0.
- Underflow: i_a=0x00, i_b=0x01 → o_diff=0xFF, o_borrow=1. Also i_a=0x80, i_b=0xFF → o_diff=0x81, o_borrow=1.
- Equal operands: i_a=0xFF, i_b=0xFF → o_diff=0x00, o_borrow=0. Result must hold unchanged for 20 idle cycles afterwards.
- Start while busy: start with 0x10/0x01, then pulse i_start with 0xAA/0x55 at RUN cycle 3 → exactly one o_done; o_diff=0x0F, o_borrow=0.
- Reset mid-operation: start with 0x40/0x20, assert i_rst asynchronously mid-cycle at RUN cycle 4 → o_busy, o_diff and o_borrow drop to 0 without waiting for a clock edge; no o_done. After release, start with 0x40/0x20 → o_diff=0x20.
- Back-to-back: assert i_start with new operands 0x03/0x05 during the DONE cycle of a prior op → accepted; o_diff=0xFE, o_borrow=1, WIDTH+1 cycles after the previous o_done.
